vga_timing_out: RTL and testbench

VGA_TIMING_OUT -- requirements
Module: vga_timing_out

---
 rtl/vga_timing_out_if.sv | 30 +++
 rtl/vga_timing_out.sv | 104 ++++++++++
 tb/tb_vga_timing_out.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_out_if.sv
// Pixel-side bundle between the VGA timing block and the object mux / DAC.
// master = timing block, slave = object mux and DAC side.
interface vga_timing_out_if;
    logic [7:0]  redIn;
    logic [7:0]  greenIn;
    logic [7:0]  blueIn;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [7:0]  redOut;
    logic [7:0]  greenOut;
    logic [7:0]  blueOut;
    logic        hSyncN;
    logic        vSyncN;
    logic        blankN;

    modport master (
        input  redIn, greenIn, blueIn,
        output pixelX, pixelY, startOfFrame,
        output redOut, greenOut, blueOut,
        output hSyncN, vSyncN, blankN
    );

    modport slave (
        output redIn, greenIn, blueIn,
        input  pixelX, pixelY, startOfFrame,
        input  redOut, greenOut, blueOut,
        input  hSyncN, vSyncN, blankN
    );
endinterface

// File: rtl/vga_timing_out.sv
// VGA raster counters plus a 2-stage aligned output path: sync, blank and colour
// at the outputs all describe the counter position from two clocks earlier.
module vga_timing_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic            clk,
    input  logic            reset,
    vga_timing_out_if.master bus
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(HT - 1);
    localparam logic [10:0] V_LAST = 11'(VT - 1);
    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_count_q, h_count_d;
    logic [10:0] v_count_q, v_count_d;

    logic visible_s0, hsync_s0, vsync_s0;
    logic visible_s1_q, hsync_s1_q, vsync_s1_q;
    logic blank_n_q, hsync_n_q, vsync_n_q;

    logic [2:0][7:0] rgb_in;
    logic [2:0][7:0] rgb_d;
    logic [2:0][7:0] rgb_q;

    always_comb begin
        h_count_d = h_count_q + 11'd1;
        v_count_d = v_count_q;
        if (h_count_q == H_LAST) begin
            h_count_d = 11'd0;
            v_count_d = (v_count_q == V_LAST) ? 11'd0 : v_count_q + 11'd1;
        end
    end

    always_comb begin
        visible_s0 = (h_count_q < H_VIS) && (v_count_q < V_VIS);
        hsync_s0   = (h_count_q >= HS_BEG) && (h_count_q < HS_END);
        vsync_s0   = (v_count_q >= VS_BEG) && (v_count_q < VS_END);
    end

    // Stage 1 lines up with the colour returned by the object mux; stage 2 is the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count_q    <= 11'd0;
            v_count_q    <= 11'd0;
            visible_s1_q <= 1'b0;
            hsync_s1_q   <= 1'b0;
            vsync_s1_q   <= 1'b0;
            blank_n_q    <= 1'b0;
            hsync_n_q    <= 1'b1;
            vsync_n_q    <= 1'b1;
        end else begin
            h_count_q    <= h_count_d;
            v_count_q    <= v_count_d;
            visible_s1_q <= visible_s0;
            hsync_s1_q   <= hsync_s0;
            vsync_s1_q   <= vsync_s0;
            blank_n_q    <= visible_s1_q;
            hsync_n_q    <= ~hsync_s1_q;
            vsync_n_q    <= ~vsync_s1_q;
        end
    end

    assign rgb_in = {bus.redIn, bus.greenIn, bus.blueIn};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign rgb_d[gi] = visible_s1_q ? rgb_in[gi] : 8'd0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign bus.pixelX       = h_count_q;
    assign bus.pixelY       = v_count_q;
    assign bus.startOfFrame = (h_count_q == 11'd0) && (v_count_q == 11'd0);
    assign bus.redOut       = rgb_q[2];
    assign bus.greenOut     = rgb_q[1];
    assign bus.blueOut      = rgb_q[0];
    assign bus.hSyncN       = hsync_n_q;
    assign bus.vSyncN       = vsync_n_q;
    assign bus.blankN       = blank_n_q;
endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: a default-timing instance and a shrunken-timing instance
// (so whole frames fit in a short run), both checked against a position-from-clock-count model.
module tb_vga_timing_out;
    localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 6;
    localparam int S_VA = 12, S_VF = 2, S_VS = 2, S_VB = 4;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FT = S_HT * S_VT;
    localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VA = 480, D_VF = 10, D_VS = 2, D_VB = 33;
    localparam int D_HT = 800;
    localparam int HIST = 4096;

    typedef struct packed {
        logic [10:0] px;
        logic [10:0] py;
        logic        sof;
        logic        hs_n;
        logic        vs_n;
        logic        blank;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_timing_out_if ifa ();
    vga_timing_out_if ifb ();

    vga_timing_out u_def (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.master)
    );

    vga_timing_out #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.master)
    );

    int total = 0;
    int bad = 0;
    int k = 0;
    bit mode_a = 1'b0;
    logic [23:0] col_a [HIST];
    logic [23:0] col_b [HIST];

    // Everything is derived from k = clocks since reset release: position is plain division.
    function automatic exp_t model(int kk, bit sm);
        int ha, hf, hs, va, vf, vs, ht, vt, h, v;
        exp_t e;
        logic [23:0] c;
        if (sm) begin
            ha = S_HA; hf = S_HF; hs = S_HS; ht = S_HT;
            va = S_VA; vf = S_VF; vs = S_VS; vt = S_VT;
        end else begin
            ha = D_HA; hf = D_HF; hs = D_HS; ht = D_HA + D_HF + D_HS + D_HB;
            va = D_VA; vf = D_VF; vs = D_VS; vt = D_VA + D_VF + D_VS + D_VB;
        end
        e = '0;
        e.px = 11'(kk % ht);
        e.py = 11'((kk / ht) % vt);
        e.sof = (e.px == 11'd0) && (e.py == 11'd0);
        e.hs_n = 1'b1;
        e.vs_n = 1'b1;
        if (kk >= 2) begin
            h = (kk - 2) % ht;
            v = ((kk - 2) / ht) % vt;
            e.hs_n  = !(h >= ha + hf && h < ha + hf + hs);
            e.vs_n  = !(v >= va + vf && v < va + vf + vs);
            e.blank = (h < ha) && (v < va);
            c = sm ? col_b[(kk - 1) % HIST] : col_a[(kk - 1) % HIST];
            if (e.blank) {e.r, e.g, e.b} = c;
        end
        return e;
    endfunction

    function automatic exp_t obs_a();
        exp_t o;
        o = {ifa.pixelX, ifa.pixelY, ifa.startOfFrame, ifa.hSyncN, ifa.vSyncN,
             ifa.blankN, ifa.redOut, ifa.greenOut, ifa.blueOut};
        return o;
    endfunction

    function automatic exp_t obs_b();
        exp_t o;
        o = {ifb.pixelX, ifb.pixelY, ifb.startOfFrame, ifb.hSyncN, ifb.vSyncN,
             ifb.blankN, ifb.redOut, ifb.greenOut, ifb.blueOut};
        return o;
    endfunction

    task automatic drive();
        logic [23:0] ca, cb;
        int xa;
        cb = 24'($urandom);
        if (mode_a) begin
            xa = (k > 0) ? (k - 1) % D_HT : 0;
            ca = {8'(xa), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
        end else begin
            ca = 24'($urandom);
        end
        col_a[k % HIST] = ca;
        col_b[k % HIST] = cb;
        {ifa.redIn, ifa.greenIn, ifa.blueIn} = ca;
        {ifb.redIn, ifb.greenIn, ifb.blueIn} = cb;
    endtask

    task automatic tick();
        @(posedge clk);
        k = k + 1;
        @(negedge clk);
        drive();
    endtask

    task automatic test_reset();
        exp_t rst_e, e;
        rst_e = '{px: 11'd0, py: 11'd0, sof: 1'b1, hs_n: 1'b1, vs_n: 1'b1,
                  blank: 1'b0, r: 8'd0, g: 8'd0, b: 8'd0};
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {ifa.redIn, ifa.greenIn, ifa.blueIn} = 24'($urandom) | 24'h010101;
            {ifb.redIn, ifb.greenIn, ifb.blueIn} = 24'($urandom) | 24'h010101;
            total += 2;
            if (obs_a() !== rst_e) begin bad++; $display("FAIL reset_a got=%h exp=%h", obs_a(), rst_e); end
            if (obs_b() !== rst_e) begin bad++; $display("FAIL reset_b got=%h exp=%h", obs_b(), rst_e); end
        end
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        drive();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            e = model(k, 1'b0);
            total++;
            if (obs_a() !== e) begin bad++; $display("FAIL release_a k=%0d got=%h exp=%h", k, obs_a(), e); end
            e = model(k, 1'b1);
            total++;
            if (obs_b() !== e) begin bad++; $display("FAIL release_b k=%0d got=%h exp=%h", k, obs_b(), e); end
            total++;
            if (ifa.blankN !== (k >= 2)) begin bad++; $display("FAIL first_blank k=%0d got=%b exp=%b", k, ifa.blankN, k >= 2); end
        end
    endtask

    task automatic test_small_frame();
        logic [10:0] px_b [HIST];
        logic prev_hs;
        int run, vs_low, blank_hi, sof_cnt, last_sof, budget;
        exp_t e;
        budget = 0;
        while (k % S_FT != 2 && budget < 2 * S_FT) begin
            tick(); px_b[k % HIST] = ifb.pixelX; budget++;
        end
        prev_hs = ifb.hSyncN; run = 0; vs_low = 0; blank_hi = 0; sof_cnt = 0; last_sof = -1;
        for (int n = 0; n < 2 * S_FT; n++) begin
            tick();
            px_b[k % HIST] = ifb.pixelX;
            e = model(k, 1'b1);
            total++;
            if (obs_b() !== e) begin bad++; $display("FAIL frame_b k=%0d got=%h exp=%h", k, obs_b(), e); end
            if (prev_hs && !ifb.hSyncN) begin
                total++;
                if (px_b[(k - 2) % HIST] !== 11'(S_HA + S_HF))
                    begin bad++; $display("FAIL hsync_start got=%0d exp=%0d", px_b[(k - 2) % HIST], S_HA + S_HF); end
                run = 0;
            end
            if (!ifb.hSyncN) run++;
            if (!prev_hs && ifb.hSyncN) begin
                total++;
                if (run != S_HS) begin bad++; $display("FAIL hsync_width got=%0d exp=%0d", run, S_HS); end
            end
            prev_hs = ifb.hSyncN;
            if (ifb.startOfFrame) begin
                if (last_sof >= 0) begin
                    total++;
                    if (k - last_sof != S_FT) begin bad++; $display("FAIL sof_period got=%0d exp=%0d", k - last_sof, S_FT); end
                end
                last_sof = k;
            end
            if (n < S_FT) begin
                if (!ifb.vSyncN) vs_low++;
                if (ifb.blankN) blank_hi++;
                if (ifb.startOfFrame) sof_cnt++;
            end
        end
        total += 3;
        if (vs_low != S_VS * S_HT) begin bad++; $display("FAIL vsync_total got=%0d exp=%0d", vs_low, S_VS * S_HT); end
        if (blank_hi != S_HA * S_VA) begin bad++; $display("FAIL blank_total got=%0d exp=%0d", blank_hi, S_HA * S_VA); end
        if (sof_cnt != 1) begin bad++; $display("FAIL sof_count got=%0d exp=1", sof_cnt); end
    endtask

    task automatic test_wrap();
        int budget;
        budget = 0;
        while (!(ifb.pixelX == 11'(S_HT - 1) && ifb.pixelY == 11'(S_VT - 1)) && budget < 2 * S_FT) begin
            tick(); budget++;
        end
        total++;
        if (budget >= 2 * S_FT) begin bad++; $display("FAIL wrap_search got=timeout exp=corner"); end
        tick();
        total += 3;
        if (ifb.pixelX !== 11'd0) begin bad++; $display("FAIL wrap_x got=%0d exp=0", ifb.pixelX); end
        if (ifb.pixelY !== 11'd0) begin bad++; $display("FAIL wrap_y got=%0d exp=0", ifb.pixelY); end
        if (ifb.startOfFrame !== 1'b1) begin bad++; $display("FAIL wrap_sof got=%b exp=1", ifb.startOfFrame); end
        budget = 0;
        while (!(ifb.pixelX == 11'(S_HT - 1) && ifb.pixelY == 11'(S_VA - 1)) && budget < 2 * S_FT) begin
            tick(); budget++;
        end
        tick();
        total++;
        if (ifb.pixelY !== 11'(S_VA)) begin bad++; $display("FAIL last_line_y got=%0d exp=%0d", ifb.pixelY, S_VA); end
        for (int i = 0; i < S_HT + 2; i++) begin
            tick();
            total++;
            if (ifb.blankN !== 1'b0) begin bad++; $display("FAIL line_va_blank k=%0d got=%b exp=0", k, ifb.blankN); end
        end
    endtask

    task automatic test_default_lines();
        logic [10:0] px_a [HIST];
        logic prev_hs;
        int run, blank_hi;
        exp_t e;
        mode_a = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); px_a[k % HIST] = ifa.pixelX; end
        prev_hs = ifa.hSyncN; run = 0; blank_hi = 0;
        for (int n = 0; n < 3 * D_HT; n++) begin
            tick();
            px_a[k % HIST] = ifa.pixelX;
            e = model(k, 1'b0);
            total++;
            if (obs_a() !== e) begin bad++; $display("FAIL line_a k=%0d got=%h exp=%h", k, obs_a(), e); end
            if (prev_hs && !ifa.hSyncN) begin
                total++;
                if (px_a[(k - 2) % HIST] !== 11'd656)
                    begin bad++; $display("FAIL hsync_start_a got=%0d exp=656", px_a[(k - 2) % HIST]); end
                run = 0;
            end
            if (!ifa.hSyncN) run++;
            if (!prev_hs && ifa.hSyncN) begin
                total++;
                if (run != 96) begin bad++; $display("FAIL hsync_width_a got=%0d exp=96", run); end
            end
            prev_hs = ifa.hSyncN;
            if (n < D_HT && ifa.blankN) blank_hi++;
        end
        total++;
        if (blank_hi != 640) begin bad++; $display("FAIL line_blank_a got=%0d exp=640", blank_hi); end
    endtask

    task automatic test_reset_midframe();
        exp_t ea, eb;
        int budget;
        budget = 0;
        ea = model(k, 1'b0);
        eb = model(k, 1'b1);
        while (!(eb.hs_n == 1'b0 && ea.blank == 1'b1 && ea.r != 8'd0) && budget < 2000) begin
            tick(); budget++;
            ea = model(k, 1'b0);
            eb = model(k, 1'b1);
        end
        total += 2;
        if (budget >= 2000) begin bad++; $display("FAIL midreset_search got=timeout exp=found"); end
        if (ifb.hSyncN !== 1'b0) begin bad++; $display("FAIL pre_reset_hs got=%b exp=0", ifb.hSyncN); end
        #2;
        reset = 1'b1;
        #1;
        total += 6;
        if (ifb.hSyncN !== 1'b1) begin bad++; $display("FAIL async_hs got=%b exp=1", ifb.hSyncN); end
        if (ifa.blankN !== 1'b0) begin bad++; $display("FAIL async_blank got=%b exp=0", ifa.blankN); end
        if ({ifa.redOut, ifa.greenOut, ifa.blueOut} !== 24'd0)
            begin bad++; $display("FAIL async_rgb got=%h exp=0", {ifa.redOut, ifa.greenOut, ifa.blueOut}); end
        if (ifa.pixelX !== 11'd0 || ifa.pixelY !== 11'd0)
            begin bad++; $display("FAIL async_pix got=%0d,%0d exp=0,0", ifa.pixelX, ifa.pixelY); end
        if (ifa.startOfFrame !== 1'b1) begin bad++; $display("FAIL async_sof got=%b exp=1", ifa.startOfFrame); end
        if (ifb.blankN !== 1'b0) begin bad++; $display("FAIL async_blank_b got=%b exp=0", ifb.blankN); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        drive();
        for (int i = 0; i < 2 * S_HT; i++) begin
            if (i > 0) tick();
            ea = model(k, 1'b0);
            eb = model(k, 1'b1);
            total += 2;
            if (obs_a() !== ea) begin bad++; $display("FAIL resume_a k=%0d got=%h exp=%h", k, obs_a(), ea); end
            if (obs_b() !== eb) begin bad++; $display("FAIL resume_b k=%0d got=%h exp=%h", k, obs_b(), eb); end
        end
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_wrap();
        test_default_lines();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
